// File: rtl/dicas_jogo_if.sv
// Bus for the dicas_jogo round controller: load/guess inputs plus hint and status outputs.
// Carries distancia only when DICAS_DISTANCIA_EN is defined.
interface dicas_jogo_if #(
    parameter int LARG_A   = 4,
    parameter int LARG_B   = 3,
    parameter int MAX_TENT = 8
);
    localparam int LT = (LARG_A > LARG_B) ? LARG_A : LARG_B;
    localparam int LC = $clog2(MAX_TENT + 1);

    logic              carrega;
    logic [LARG_A-1:0] senhaA;
    logic [LARG_B-1:0] senhaB;
    logic [LT-1:0]     tentativa;
    logic              confirma;
    logic [1:0]        comp;
    logic              valido;
    logic              paridade;
    logic              modoB;
    logic [LC-1:0]     restantes;
    logic              acertou;
    logic              bloqueado;
`ifdef DICAS_DISTANCIA_EN
    logic [LT-1:0]     distancia;
`endif

    modport master (
        output carrega, senhaA, senhaB, tentativa, confirma,
        input  comp, valido, paridade, modoB, restantes, acertou, bloqueado
`ifdef DICAS_DISTANCIA_EN
        , input distancia
`endif
    );

    modport slave (
        input  carrega, senhaA, senhaB, tentativa, confirma,
        output comp, valido, paridade, modoB, restantes, acertou, bloqueado
`ifdef DICAS_DISTANCIA_EN
        , output distancia
`endif
    );
endinterface

// File: rtl/dicas_jogo.sv
// Two-field password-guessing round controller with shared attempt budget and registered hints.
// Optional DICAS_DISTANCIA_EN adds a registered |guess - secret| output.
//
// state     | meaning
// ----------+-----------------------------------------------
// OCIOSO    | no round loaded, guesses ignored
// ADIV_A    | guessing secret A
// ADIV_B    | guessing secret B
// ACERTOU   | both fields found, round won
// BLOQUEADO | budget exhausted, round lost
module dicas_jogo #(
    parameter int LARG_A   = 4,
    parameter int LARG_B   = 3,
    parameter int MAX_TENT = 8
) (
    input  logic         clk,
    input  logic         rst,
    dicas_jogo_if.slave  bus
);
    localparam int LT = (LARG_A > LARG_B) ? LARG_A : LARG_B;
    localparam int LC = $clog2(MAX_TENT + 1);

    localparam logic [1:0] DICA_MENOR  = 2'b00;
    localparam logic [1:0] DICA_MAIOR  = 2'b01;
    localparam logic [1:0] DICA_IGUAL  = 2'b10;
    localparam logic [1:0] DICA_NENHUM = 2'b11;

    typedef enum logic [2:0] {OCIOSO, ADIV_A, ADIV_B, ACERTOU, BLOQUEADO} estado_t;

    estado_t           estado, estadoProx;
    logic [LARG_A-1:0] secretA, secretAProx;
    logic [LARG_B-1:0] secretB, secretBProx;
    logic [1:0]        comp, compProx;
    logic              valido, validoProx;
    logic              paridade, paridadeProx;
    logic [LC-1:0]     restantes, restantesProx;
    logic [LC-1:0]     restDec;
    logic [LT-1:0]     alvo;
`ifdef DICAS_DISTANCIA_EN
    logic [LT-1:0]     distancia, distanciaProx;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            estado    <= OCIOSO;
            secretA   <= '0;
            secretB   <= '0;
            comp      <= DICA_NENHUM;
            valido    <= 1'b0;
            paridade  <= 1'b0;
            restantes <= '0;
`ifdef DICAS_DISTANCIA_EN
            distancia <= '0;
`endif
        end else begin
            estado    <= estadoProx;
            secretA   <= secretAProx;
            secretB   <= secretBProx;
            comp      <= compProx;
            valido    <= validoProx;
            paridade  <= paridadeProx;
            restantes <= restantesProx;
`ifdef DICAS_DISTANCIA_EN
            distancia <= distanciaProx;
`endif
        end
    end

    always_comb begin
        estadoProx    = estado;
        secretAProx   = secretA;
        secretBProx   = secretB;
        compProx      = comp;
        validoProx    = 1'b0;
        paridadeProx  = paridade;
        restantesProx = restantes;
        restDec       = restantes - LC'(1);
        alvo          = (estado == ADIV_B) ? LT'(secretB) : LT'(secretA);
`ifdef DICAS_DISTANCIA_EN
        distanciaProx = distancia;
`endif

        // A load always wins over a simultaneous guess.
        if (bus.carrega) begin
            secretAProx   = bus.senhaA;
            secretBProx   = bus.senhaB;
            paridadeProx  = (^bus.senhaA) ^ (^bus.senhaB);
            restantesProx = LC'(MAX_TENT);
            compProx      = DICA_NENHUM;
            estadoProx    = ADIV_A;
`ifdef DICAS_DISTANCIA_EN
            distanciaProx = '0;
`endif
        end else if (bus.confirma && (estado == ADIV_A || estado == ADIV_B)) begin
            validoProx    = 1'b1;
            restantesProx = restDec;
            if (bus.tentativa < alvo)
                compProx = DICA_MENOR;
            else if (bus.tentativa > alvo)
                compProx = DICA_MAIOR;
            else
                compProx = DICA_IGUAL;
`ifdef DICAS_DISTANCIA_EN
            distanciaProx = (bus.tentativa >= alvo) ? (bus.tentativa - alvo) : (alvo - bus.tentativa);
`endif
            // Field B found wins even on the last attempt; field A found on the last attempt loses.
            if (bus.tentativa == alvo) begin
                if (estado == ADIV_B)
                    estadoProx = ACERTOU;
                else if (restDec != '0)
                    estadoProx = ADIV_B;
                else
                    estadoProx = BLOQUEADO;
            end else if (restDec == '0) begin
                estadoProx = BLOQUEADO;
            end
        end
    end

    assign bus.comp      = comp;
    assign bus.valido    = valido;
    assign bus.paridade  = paridade;
    assign bus.restantes = restantes;
    assign bus.modoB     = (estado == ADIV_B);
    assign bus.acertou   = (estado == ACERTOU);
    assign bus.bloqueado = (estado == BLOQUEADO);
`ifdef DICAS_DISTANCIA_EN
    assign bus.distancia = distancia;
`endif
endmodule

// File: tb/tb_dicas_jogo.sv
// Bench for dicas_jogo: vector table, lockout sequences on a MAX_TENT=2 instance, random run against a rule model.
module tb_dicas_jogo;
    localparam int MAX1 = 8;
    localparam int MAX2 = 2;

    logic clk = 1'b0;
    logic rst1, rst2;
    always #5 clk = ~clk;

    dicas_jogo_if #(.LARG_A(4), .LARG_B(3), .MAX_TENT(MAX1)) bus1();
    dicas_jogo_if #(.LARG_A(4), .LARG_B(3), .MAX_TENT(MAX2)) bus2();

    dicas_jogo #(.LARG_A(4), .LARG_B(3), .MAX_TENT(MAX1)) dut1 (.clk(clk), .rst(rst1), .bus(bus1));
    dicas_jogo #(.LARG_A(4), .LARG_B(3), .MAX_TENT(MAX2)) dut2 (.clk(clk), .rst(rst2), .bus(bus2));

    int checks = 0;
    int errors = 0;

    // Reference model of the round, expressed as game rules.
    int mPhase;   // 0 idle, 1 guessing A, 2 guessing B, 3 won, 4 lost
    int mLeft, mComp, mValid, mSecA, mSecB, mPar, mDist;

    typedef struct {
        logic        rst;
        logic        carrega;
        logic [3:0]  sA;
        logic [2:0]  sB;
        logic [3:0]  t;
        logic        conf;
        logic [10:0] exp;
    } vec_t;
    vec_t vecs[14];

    function automatic logic [10:0] e(int comp, int v, int rest, int mB, int ac, int bl, int par);
        return {comp[1:0], v[0], rest[3:0], mB[0], ac[0], bl[0], par[0]};
    endfunction

    function automatic logic [10:0] got1();
        return {bus1.comp, bus1.valido, 4'(bus1.restantes), bus1.modoB, bus1.acertou, bus1.bloqueado, bus1.paridade};
    endfunction

    function automatic logic [10:0] got2();
        return {bus2.comp, bus2.valido, 4'(bus2.restantes), bus2.modoB, bus2.acertou, bus2.bloqueado, bus2.paridade};
    endfunction

    function automatic logic [10:0] modelOut();
        return e(mComp, mValid, mLeft, int'(mPhase == 2), int'(mPhase == 3), int'(mPhase == 4), mPar);
    endfunction

    task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {comp,valido,restantes,modoB,acertou,bloqueado,paridade}=%b expected %b", name, act, exp);
        end
    endtask

    task automatic chkVal(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic modelStep(input logic r, input logic c, input int sa, input int sb, input int t, input logic cf);
        int target;
        mValid = 0;
        if (r) begin
            mPhase = 0; mLeft = 0; mComp = 3; mSecA = 0; mSecB = 0; mPar = 0; mDist = 0;
        end else if (c) begin
            mSecA = sa; mSecB = sb; mLeft = MAX1; mComp = 3; mPhase = 1; mDist = 0;
            mPar = ($countones(sa) + $countones(sb)) % 2;
        end else if (cf && (mPhase == 1 || mPhase == 2)) begin
            target = (mPhase == 1) ? mSecA : mSecB;
            mComp  = (t < target) ? 0 : (t > target) ? 1 : 2;
            mDist  = (t > target) ? t - target : target - t;
            mValid = 1;
            mLeft  = mLeft - 1;
            if (mComp == 2) mPhase = (mPhase == 2) ? 3 : (mLeft > 0 ? 2 : 4);
            else if (mLeft == 0) mPhase = 4;
        end
    endtask

    task automatic apply1(input logic r, input logic c, input int sa, input int sb, input int t, input logic cf);
        rst1 = r; bus1.carrega = c; bus1.senhaA = 4'(sa); bus1.senhaB = 3'(sb);
        bus1.tentativa = 4'(t); bus1.confirma = cf;
        modelStep(r, c, sa, sb, t, cf);
        @(posedge clk); #1;
        rst1 = 1'b0; bus1.carrega = 1'b0; bus1.confirma = 1'b0;
    endtask

    task automatic apply2(input logic c, input int sa, input int sb, input int t, input logic cf);
        bus2.carrega = c; bus2.senhaA = 4'(sa); bus2.senhaB = 3'(sb);
        bus2.tentativa = 4'(t); bus2.confirma = cf;
        @(posedge clk); #1;
        bus2.carrega = 1'b0; bus2.confirma = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 4'd9, 3'd5, 4'd0,  1'b0, e(3, 0, 8, 0, 0, 0, 0)};
        vecs[1]  = '{1'b0, 1'b0, 4'd0, 3'd0, 4'd3,  1'b1, e(0, 1, 7, 0, 0, 0, 0)};
        vecs[2]  = '{1'b0, 1'b0, 4'd0, 3'd0, 4'd12, 1'b1, e(1, 1, 6, 0, 0, 0, 0)};
        vecs[3]  = '{1'b0, 1'b0, 4'd0, 3'd0, 4'd9,  1'b1, e(2, 1, 5, 1, 0, 0, 0)};
        vecs[4]  = '{1'b0, 1'b0, 4'd0, 3'd0, 4'd5,  1'b1, e(2, 1, 4, 0, 1, 0, 0)};
        vecs[5]  = '{1'b0, 1'b0, 4'd0, 3'd0, 4'd5,  1'b1, e(2, 0, 4, 0, 1, 0, 0)};
        vecs[6]  = '{1'b0, 1'b0, 4'd0, 3'd0, 4'd0,  1'b0, e(2, 0, 4, 0, 1, 0, 0)};
        vecs[7]  = '{1'b0, 1'b1, 4'd3, 3'd7, 4'd3,  1'b1, e(3, 0, 8, 0, 0, 0, 1)};
        vecs[8]  = '{1'b0, 1'b0, 4'd0, 3'd0, 4'd3,  1'b1, e(2, 1, 7, 1, 0, 0, 1)};
        vecs[9]  = '{1'b0, 1'b0, 4'd0, 3'd0, 4'd8,  1'b1, e(1, 1, 6, 1, 0, 0, 1)};
        vecs[10] = '{1'b0, 1'b0, 4'd0, 3'd0, 4'd7,  1'b1, e(2, 1, 5, 0, 1, 0, 1)};
        vecs[11] = '{1'b0, 1'b1, 4'd1, 3'd0, 4'd0,  1'b0, e(3, 0, 8, 0, 0, 0, 1)};
        vecs[12] = '{1'b0, 1'b0, 4'd0, 3'd0, 4'd0,  1'b1, e(0, 1, 7, 0, 0, 0, 1)};
        vecs[13] = '{1'b1, 1'b0, 4'd0, 3'd0, 4'd1,  1'b1, e(3, 0, 0, 0, 0, 0, 0)};

        rst1 = 1'b1; rst2 = 1'b1;
        bus1.carrega = 1'b0; bus1.confirma = 1'b0; bus1.senhaA = '0; bus1.senhaB = '0; bus1.tentativa = '0;
        bus2.carrega = 1'b0; bus2.confirma = 1'b0; bus2.senhaA = '0; bus2.senhaB = '0; bus2.tentativa = '0;
        apply1(1'b1, 1'b0, 0, 0, 0, 1'b0);
        apply1(1'b1, 1'b0, 0, 0, 0, 1'b0);
        rst2 = 1'b0;
        chk("reset1", got1(), e(3, 0, 0, 0, 0, 0, 0));
        chk("reset2", got2(), e(3, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < 14; i++) begin
            apply1(vecs[i].rst, vecs[i].carrega, int'(vecs[i].sA), int'(vecs[i].sB), int'(vecs[i].t), vecs[i].conf);
            chk($sformatf("vec%0d", i), got1(), vecs[i].exp);
`ifdef DICAS_DISTANCIA_EN
            chkVal($sformatf("vec%0d_dist", i), int'(bus1.distancia), mDist);
`endif
        end

        // Lockout after two wrong guesses, then reload.
        apply2(1'b1, 9, 5, 0, 1'b0);  chk("lock_load", got2(), e(3, 0, 2, 0, 0, 0, 0));
        apply2(1'b0, 0, 0, 3, 1'b1);  chk("lock_g1", got2(), e(0, 1, 1, 0, 0, 0, 0));
`ifdef DICAS_DISTANCIA_EN
        chkVal("dist_3", int'(bus2.distancia), 6);
`endif
        apply2(1'b0, 0, 0, 12, 1'b1); chk("lock_g2", got2(), e(1, 1, 0, 0, 0, 1, 0));
`ifdef DICAS_DISTANCIA_EN
        chkVal("dist_12", int'(bus2.distancia), 3);
`endif
        apply2(1'b0, 0, 0, 9, 1'b1);  chk("lock_ignore", got2(), e(1, 0, 0, 0, 0, 1, 0));
        apply2(1'b1, 9, 5, 0, 1'b0);  chk("lock_reload", got2(), e(3, 0, 2, 0, 0, 0, 0));
`ifdef DICAS_DISTANCIA_EN
        chkVal("dist_clear", int'(bus2.distancia), 0);
`endif
        // Field A found on the last attempt still loses.
        apply2(1'b0, 0, 0, 1, 1'b1);  chk("lastA_g1", got2(), e(0, 1, 1, 0, 0, 0, 0));
        apply2(1'b0, 0, 0, 9, 1'b1);  chk("lastA_eq", got2(), e(2, 1, 0, 0, 0, 1, 0));
        // Field B found on the last attempt wins.
        apply2(1'b1, 9, 5, 0, 1'b0);
        apply2(1'b0, 0, 0, 9, 1'b1);  chk("lastB_a", got2(), e(2, 1, 1, 1, 0, 0, 0));
        apply2(1'b0, 0, 0, 5, 1'b1);  chk("lastB_win", got2(), e(2, 1, 0, 0, 1, 0, 0));

        // Random rounds against the rule model.
        for (int n = 0; n < 600; n++) begin
            logic r, c, cf;
            int sa, sb, t, target;
            r  = ($urandom_range(0, 79) == 0);
            c  = ($urandom_range(0, 11) == 0);
            cf = ($urandom_range(0, 2) != 0);
            sa = $urandom_range(0, 15);
            sb = $urandom_range(0, 7);
            target = (mPhase == 2) ? mSecB : mSecA;
            t  = ($urandom_range(0, 2) == 0) ? target : $urandom_range(0, 15);
            apply1(r, c, sa, sb, t, cf);
            chk($sformatf("rand%0d", n), got1(), modelOut());
`ifdef DICAS_DISTANCIA_EN
            chkVal($sformatf("rand%0d_dist", n), int'(bus1.distancia), mDist);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
